// File: rtl/chrom_serial_loader.sv
// ---------------------------------------------------------------------------
// chrom_serial_loader
//   Receives a chromosome as a byte frame (HEADER, NBYTES payload bytes,
//   XOR checksum) over a valid/ready stream. The payload is assembled in a
//   shadow register and copied to the chrom bus in one step only after the
//   checksum matches, so the evolvable circuit never sees a partial or
//   corrupted chromosome.
//
// Ports
//   clk           in   1           rising-edge clock
//   rst           in   1           synchronous active-high reset
//   rx_data       in   8           incoming byte
//   rx_valid      in   1           rx_data valid
//   rx_ready      out  1           byte taken on cycles with rx_valid && rx_ready
//   chrom         out  CHROM_BITS  committed chromosome (bit 0 = LSB of payload byte 0)
//   chrom_valid   out  1           high once any frame has committed since reset
//   chrom_update  out  1           one-cycle pulse in the cycle chrom takes a new value
//   err_pulse     out  1           one-cycle pulse on checksum failure or timeout
//   busy          out  1           high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module chrom_serial_loader #(
    parameter int             CHROM_BITS  = 25,
    parameter logic [7:0]     HEADER      = 8'hA5,
    parameter int             TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [CHROM_BITS-1:0] chrom,
    output logic                  chrom_valid,
    output logic                  chrom_update,
    output logic                  err_pulse,
    output logic                  busy
);

    localparam int NBYTES = (CHROM_BITS + 7) / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Running checksum update: every received payload byte folds in,
    // including pad bits above CHROM_BITS in the last byte.
    function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IDX_W-1:0]        byte_idx_r;
    logic [7:0]              xor_r;
    logic [TO_W-1:0]         tcnt_r;
    logic [CHROM_BITS-1:0]   shadow_r;
    logic [CHROM_BITS-1:0]   shadow_next_s;
    logic [CHROM_BITS-1:0]   chrom_r;
    logic                    chrom_valid_r;
    logic                    chrom_update_r;
    logic                    err_pulse_r;

    logic                    accept_s;
    logic                    in_frame_s;
    logic                    timeout_s;
    logic                    start_s;
    logic                    load_byte_s;
    logic                    commit_s;
    logic                    err_set_s;

    // Handshake and frame-level qualifiers.
    always_comb begin
        accept_s   = rx_valid && (state_r != ST_COMMIT);
        in_frame_s = (state_r == ST_LOAD) || (state_r == ST_CHECK);
        timeout_s  = in_frame_s && !accept_s && (tcnt_r == TO_LAST);
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        load_byte_s  = 1'b0;
        commit_s     = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Non-header bytes while idle are dropped without an error.
                if (accept_s && (rx_data == HEADER)) begin
                    state_next_s = ST_LOAD;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // A header value here is ordinary payload, never a resync.
                if (accept_s) begin
                    load_byte_s = 1'b1;
                    if (byte_idx_r == LAST_IDX) begin
                        state_next_s = ST_CHECK;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                    err_set_s    = 1'b1;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (rx_data == xor_r) begin
                        state_next_s = ST_COMMIT;
                    end else begin
                        state_next_s = ST_IDLE;
                        err_set_s    = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                    err_set_s    = 1'b1;
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            ST_COMMIT: begin
                state_next_s = ST_IDLE;
                commit_s     = 1'b1;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Shadow write: only bits below CHROM_BITS are stored; pad bits are
    // seen by the checksum alone.
    always_comb begin
        shadow_next_s = shadow_r;
        if (load_byte_s) begin
            for (int b = 0; b < CHROM_BITS; b++) begin
                if (byte_idx_r == IDX_W'(b / 8)) begin
                    shadow_next_s[b] = rx_data[b % 8];
                end else begin
                    shadow_next_s[b] = shadow_r[b];
                end
            end
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Byte index, checksum accumulator and shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_r <= '0;
            xor_r      <= 8'h00;
            shadow_r   <= '0;
        end else begin
            shadow_r <= shadow_next_s;
            if (start_s) begin
                byte_idx_r <= '0;
                xor_r      <= 8'h00;
            end else if (load_byte_s) begin
                byte_idx_r <= byte_idx_r + IDX_W'(1);
                xor_r      <= xor_accum(xor_r, rx_data);
            end
        end
    end

    // Inter-byte idle counter; only runs while a frame is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_r <= '0;
        end else if (!in_frame_s || accept_s || timeout_s) begin
            tcnt_r <= '0;
        end else begin
            tcnt_r <= tcnt_r + TO_W'(1);
        end
    end

    // Committed chromosome and status pulses; chrom moves only on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            chrom_r        <= '0;
            chrom_valid_r  <= 1'b0;
            chrom_update_r <= 1'b0;
            err_pulse_r    <= 1'b0;
        end else begin
            chrom_update_r <= commit_s;
            err_pulse_r    <= err_set_s;
            if (commit_s) begin
                chrom_r       <= shadow_r;
                chrom_valid_r <= 1'b1;
            end
        end
    end

    assign chrom        = chrom_r;
    assign chrom_valid  = chrom_valid_r;
    assign chrom_update = chrom_update_r;
    assign err_pulse    = err_pulse_r;
    assign rx_ready     = (state_r != ST_COMMIT);
    assign busy         = (state_r != ST_IDLE);

endmodule
